// File: rtl/audio_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the audio DAC serializer slice.
// Frame formats, serializer state encoding and counter limits.
package audio_pkg;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  typedef enum logic {
    IDLE,
    PLAY
  } ser_state_t;

endpackage

// File: rtl/audio_dac_serializer_if.sv
`timescale 1ns/1ps
// Valid/ready sample-pair bundle between the sound source
// and the DAC serializer.
interface audio_dac_serializer_if #(
  parameter int SAMPLE_W = 24
);

  logic [SAMPLE_W-1:0] in_left;
  logic [SAMPLE_W-1:0] in_right;
  logic                in_valid;
  logic                in_ready;

  modport master (
    output in_left,
    output in_right,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_left,
    input  in_right,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/audio_sample_fifo.sv
`timescale 1ns/1ps
// First-word fall-through FIFO holding stereo pairs.
// Occupancy is derived from wrap-bit pointers.
module audio_sample_fifo #(
  parameter int  W     = 48,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign level  = r_wptr - r_rptr;
  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);
  assign rdata  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
`timescale 1ns/1ps
// DAC-side serializer for a codec in master mode: buffers stereo
// pairs and shifts them out MSB-first on synchronised bclk falls.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int   SAMPLE_W   = 24,
  parameter int   FIFO_DEPTH = 4,
  parameter logic MODE       = MODE_I2S,
  localparam int  LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic                  daclrc,
  output logic                  dacdat,
  audio_dac_serializer_if.slave s_if,
  input  logic                  enable,
  output logic                  frame_start,
  output logic [15:0]           underrun_count,
  output logic [LW-1:0]         fifo_level
);

  localparam int DELAY = (MODE == MODE_LJ) ? 0 : 1;
  localparam logic [7:0]    CNT_END  = 8'(SAMPLE_W + DELAY);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic r_bclk_s1, r_bclk_s2, r_bclk_h;
  logic r_lrc_s1, r_lrc_s2, r_lrc_h;

  logic w_fall, w_slot, w_left, w_right;
  logic w_push, w_pop, w_full, w_empty;
  logic [2*SAMPLE_W-1:0] w_rdata;
  logic [SAMPLE_W-1:0]   w_word;
  logic [LW-1:0]         w_level_nxt;

  logic                r_ready;
  ser_state_t          r_state;
  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] r_hold;
  logic [7:0]          r_cnt;

  // daclrc history is taken only at falls, so it holds the last slot's side
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_h  <= 1'b0;
      r_lrc_s1  <= 1'b0;
      r_lrc_s2  <= 1'b0;
      r_lrc_h   <= 1'b0;
    end else begin
      r_bclk_s1 <= bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_h  <= r_bclk_s2;
      r_lrc_s1  <= daclrc;
      r_lrc_s2  <= r_lrc_s1;
      if (w_fall) r_lrc_h <= r_lrc_s2;
    end
  end

  assign w_fall  = r_bclk_h & ~r_bclk_s2;
  assign w_slot  = w_fall & (r_lrc_s2 ^ r_lrc_h);
  assign w_left  = w_slot & ~r_lrc_s2;
  assign w_right = w_slot & r_lrc_s2;

  assign w_pop  = w_left & enable & ~w_empty;
  assign w_push = s_if.in_valid & s_if.in_ready;

  assign s_if.in_ready = r_ready & ~reset;

  assign w_level_nxt = fifo_level + LW'(w_push) - LW'(w_pop);

  audio_sample_fifo #(
    .W     (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_pop),
    .wdata   ({s_if.in_left, s_if.in_right}),
    .rdata   (w_rdata),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  always_comb begin
    w_word = r_hold;
    if (w_left) begin
      w_word = w_pop ? w_rdata[2*SAMPLE_W-1:SAMPLE_W] : '0;
    end
  end

  // r_cnt holds the slot position of the next fall; the edge itself is 0
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_shift        <= '0;
      r_hold         <= '0;
      r_cnt          <= '0;
      r_ready        <= 1'b1;
      dacdat         <= 1'b0;
      frame_start    <= 1'b0;
      underrun_count <= '0;
    end else begin
      r_ready     <= w_full ? w_pop : (w_level_nxt != LVL_FULL);
      frame_start <= w_pop;
      if (w_left || (w_right && r_state == PLAY)) begin
        r_cnt   <= 8'd1;
        r_shift <= (DELAY == 0) ? (w_word << 1) : w_word;
        dacdat  <= (DELAY == 0) ? w_word[SAMPLE_W-1] : 1'b0;
        if (w_left) begin
          r_state <= PLAY;
          r_hold  <= w_pop ? w_rdata[SAMPLE_W-1:0] : '0;
          if (enable && w_empty &&
              underrun_count != UNDERRUN_MAX) begin
            underrun_count <= underrun_count + 16'd1;
          end
        end
      end else if (w_fall && r_state == PLAY) begin
        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        dacdat  <= (r_cnt < CNT_END) ? r_shift[SAMPLE_W-1] : 1'b0;
        r_shift <= r_shift << 1;
      end
    end
  end

endmodule
